// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: shift-add mantissa product retiring
// BITS_PER_CYCLE multiplier bits per cycle, round-to-nearest-even, flush-to-zero.
module fp_mul_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op,
  output logic [1:0]  state_dbg
);
  // Handshake: a transfer happens on any rising edge where valid and ready are both
  // high; valid never drops and data never changes until that edge occurs.
  localparam int K = BITS_PER_CYCLE;
  localparam int N = 24 / K;
  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;
  state_t state, state_nxt;

  logic               sign;
  logic signed [9:0]  exp_base;
  logic [23:0]        ma, mb_sh;
  logic [47:0]        acc;
  logic [4:0]         cnt;

  // Operand classification straight off the input bus
  logic [7:0] ea, eb;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, accept;
  logic [31:0] special_op;

  always_comb begin
    ea      = a[30:23];
    eb      = b[30:23];
    a_nan   = (&ea) && (|a[22:0]);
    b_nan   = (&eb) && (|b[22:0]);
    a_inf   = (&ea) && !(|a[22:0]);
    b_inf   = (&eb) && !(|b[22:0]);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_op = 32'h7FC00000;
    else if (a_inf || b_inf)
      special_op = {a[31] ^ b[31], 8'hFF, 23'h0};
    else
      special_op = {a[31] ^ b[31], 31'h0};
    accept = in_valid && (state == IDLE);
  end

  // Partial products for this cycle, placed at the current bit offset
  logic [23+K:0] part;
  logic [5:0]    sh;
  logic [47:0]   pp;

  always_comb begin
    part = (24 + K)'(ma) * (24 + K)'(mb_sh[K-1:0]);
    sh   = 6'(int'(cnt) * K);
    pp   = 48'(part) << sh;
  end

  // Normalize and round the finished product
  logic               norm, guard, sticky, round_up, carry;
  logic [23:0]        mant, mant_fin;
  logic [24:0]        mant_r;
  logic signed [9:0]  e_fin;
  logic [31:0]        rnd_op;

  always_comb begin
    norm     = acc[47];
    mant     = norm ? acc[47:24] : acc[46:23];
    guard    = norm ? acc[23] : acc[22];
    sticky   = norm ? (|acc[22:0]) : (|acc[21:0]);
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {24'h0, round_up};
    carry    = mant_r[24];
    mant_fin = carry ? mant_r[24:1] : mant_r[23:0];
    e_fin    = exp_base + $signed({9'h0, norm}) + $signed({9'h0, carry});
    if (e_fin >= 10'sd255)
      rnd_op = {sign, 8'hFF, 23'h0};
    else if (e_fin <= 10'sd0)
      rnd_op = {sign, 31'h0};
    else
      rnd_op = {sign, e_fin[7:0], mant_fin[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : MUL;
      MUL:  if (cnt == LAST) state_nxt = RND;
      RND:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      exp_base <= '0;
      ma       <= '0;
      mb_sh    <= '0;
      acc      <= '0;
      cnt      <= '0;
      op       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign     <= a[31] ^ b[31];
          exp_base <= {2'b00, ea} + {2'b00, eb} - 10'd127;
          ma       <= {1'b1, a[22:0]};
          mb_sh    <= {1'b1, b[22:0]};
          acc      <= '0;
          cnt      <= '0;
          if (special) op <= special_op;
        end
        MUL: begin
          acc   <= acc + pp;
          mb_sh <= mb_sh >> K;
          cnt   <= cnt + 5'd1;
        end
        RND: op <= rnd_op;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: two instances (1 and 4 bits per cycle) share
// the request side and are checked for result and accept-to-valid latency.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        r1_in_ready, r1_out_valid, r4_in_ready, r4_out_valid;
  logic [31:0] r1_op, r4_op;
  logic [1:0]  r1_state, r4_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
    .a(a), .b(b), .out_valid(r1_out_valid), .out_ready(out_ready),
    .op(r1_op), .state_dbg(r1_state)
  );

  fp_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4_in_ready),
    .a(a), .b(b), .out_valid(r4_out_valid), .out_ready(out_ready),
    .op(r4_op), .state_dbg(r4_state)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] vexp;
    logic        special;
  } vec_t;

  vec_t vecs[14];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts and ends at posedge+1
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vexp, input logic special,
                        input int gap_in, input int gap_out);
    int lat1, lat4, cyc;
    repeat (gap_in) begin @(posedge clk); #1; end
    a = va;
    b = vb;
    in_valid = 1'b1;
    check32("in_ready_idle_1", {31'h0, r1_in_ready}, 32'h1);
    check32("in_ready_idle_4", {31'h0, r4_in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat1 = 0;
    lat4 = 0;
    cyc = 1;
    while ((lat1 == 0 || lat4 == 0) && cyc <= 60) begin
      if (lat1 == 0 && r1_out_valid) lat1 = cyc;
      if (lat4 == 0 && r4_out_valid) lat4 = cyc;
      if (lat1 == 0 || lat4 == 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_int($sformatf("latency_1 %h*%h", va, vb), lat1, special ? 1 : 26);
    check_int($sformatf("latency_4 %h*%h", va, vb), lat4, special ? 1 : 8);
    check32($sformatf("op_1 %h*%h", va, vb), r1_op, vexp);
    check32($sformatf("op_4 %h*%h", va, vb), r4_op, vexp);
    repeat (gap_out) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check32("release_1", {30'h0, r1_in_ready, r1_out_valid}, 32'h2);
    check32("release_4", {30'h0, r4_in_ready, r4_out_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] held1, held4;
    int wait_cyc;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1]  = '{32'h40400000, 32'hC0A00000, 32'hC1700000, 1'b0};
    vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1};
    vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0};
    vecs[7]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b1};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1};
    vecs[10] = '{32'h40000000, 32'h40000000, 32'h40800000, 1'b0};
    vecs[11] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0};
    vecs[12] = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b1};
    vecs[13] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b0};

    // Reset state
    #1;
    check32("reset_op_1", r1_op, 32'h0);
    check32("reset_op_4", r4_op, 32'h0);
    check32("reset_flags_1", {29'h0, r1_in_ready, r1_out_valid, 1'b0} | {30'h0, r1_state}, 32'h4);
    check32("reset_flags_4", {29'h0, r4_in_ready, r4_out_valid, 1'b0} | {30'h0, r4_state}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, vecs[i].special, 0, 0);

    // Backpressure: result held, inputs ignored while DONE
    a = 32'h40000000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!(r1_out_valid && r4_out_valid) && wait_cyc < 60) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check32("bp_valid", {30'h0, r1_out_valid, r4_out_valid}, 32'h3);
    held1 = r1_op;
    held4 = r4_op;
    check32("bp_op_1", held1, 32'h40C00000);
    check32("bp_op_4", held4, 32'h40C00000);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check32("bp_hold_1", r1_op, held1);
      check32("bp_hold_4", r4_op, held4);
      check32("bp_ready", {28'h0, r1_in_ready, r4_in_ready, r1_out_valid, r4_out_valid}, 32'h3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check32("bp_release", {28'h0, r1_in_ready, r4_in_ready, r1_out_valid, r4_out_valid}, 32'hC);

    // Reset during MUL cycle 5
    a = 32'h40400000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check32("rst_op_1", r1_op, 32'h0);
    check32("rst_op_4", r4_op, 32'h0);
    check32("rst_flags", {28'h0, r1_in_ready, r4_in_ready, r1_out_valid, r4_out_valid}, 32'hC);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 0, 0);

    // Regression pass with random request and consume gaps
    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, vecs[i].special,
             $urandom_range(0, 3), $urandom_range(0, 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Sequential IEEE-754 single-precision multiplier with valid/ready handshakes on both sides. It computes the same `op = a * b` as the combinational `multi` datapath, but uses a radix-configurable shift-add mantissa multiplier instead of a 24×24 array. It sits behind a requester that presents operand pairs and consumes results, and trades latency for area. It is verified against the same `mult.tv` vector format (`{a, b, opexp}`, hex).

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8, 12, 24. Define N = 24 / BITS_PER_CYCLE.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset. Asserts asynchronously; releases synchronously to `clk`.
- `in_valid  in  1`: operand pair on `a` and `b` is valid.
- `in_ready  out  1`: block can accept an operand pair. High only in IDLE.
- `a  in  32`: operand A, IEEE-754 binary32.
- `b  in  32`: operand B, IEEE-754 binary32.
- `out_valid  out  1`: `op` holds a finished result.
- `out_ready  in  1`: consumer accepts `op`.
- `op  out  32`: product, binary32, registered.

## Operation
- States: IDLE, MUL, RND, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `a` and `b`, unpack sign, exponent and mantissa with the hidden bit.
  - Special operand → load `op` directly, go to DONE.
  - Otherwise → MUL.
- **MUL**: N cycles. Each cycle adds `BITS_PER_CYCLE` partial products of the 24-bit mantissas into a 48-bit accumulator. A cycle counter runs 0..N-1; at N-1 → RND.
- **RND**: one cycle.
  - Normalize: if `prod[47]`, take `prod[47:24]` and exp+1. Otherwise take `prod[46:23]`.
  - Form guard bit and sticky bit (OR of the remaining low bits).
  - Round to nearest, ties to even. A rounding carry out of the mantissa increments the exponent.
  - Load `op`, then → DONE.
- **DONE**
  - `out_valid` = 1; `op` holds stable.
  - On `out_ready` → IDLE.
- **Exponent arithmetic**: 10-bit signed. e = ea + eb − 127, plus the normalize and round increments.
  - e ≥ 255 → signed infinity (`{s, 8'hFF, 23'h0}`).
  - e ≤ 0 → signed zero (flush to zero, no denormal output).
- Sign = `sa ^ sb` for every result except NaN.
- **Special cases**, resolved in IDLE in priority order:
  1. Either input NaN, or inf × zero → `0x7FC00000`.
  2. Either input inf → signed inf.
  3. Either input zero or denormal (exp = 0) → signed zero. Denormal inputs are flushed to zero.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready` = 1
  - `out_valid` = 0
  - `op` = `0x00000000`
  - accumulator and counter = 0
- Latency is measured from the accept edge (`in_valid & in_ready`) to the first cycle with `out_valid` = 1.
  - Normal operands: N + 2 cycles (N MUL cycles + 1 RND cycle + the DONE-entry edge).
  - Special operands: 1 cycle.
- Throughput: one result per N + 3 cycles (normal operands) when `out_ready` is held high, since DONE → IDLE costs one cycle.
- `in_ready` is 0 in MUL, RND and DONE. `in_valid` in those states is ignored, and the operands are not sampled.
- `out_valid` stays high, with `op` unchanged, until `out_ready` is sampled high. There is no upper bound on stall.
- `out_ready` is ignored while `out_valid` = 0.
- `rst_n` low in any state:
  - Immediately aborts the operation.
  - Outputs go to reset values in the same cycle (asynchronous).
  - No result is produced for the aborted operands.

## Test plan
- **Normal products**, with `BITS_PER_CYCLE` = 1 and 4:
  - `a=0x3FC00000`, `b=0x40000000` → `op=0x40400000`.
  - `a=0x40400000`, `b=0xC0A00000` → `op=0xC1700000`.
  - `out_valid` rises exactly N+2 cycles after accept (26 and 8 cycles respectively).
- **Rounding**:
  - `0x3F800001 × 0x3FC00000` → `0x3FC00002` (tie rounds to even).
  - `0x3F800001 × 0x3F800001` → `0x3F800002` (below half, truncates).
- **Specials and range**, each with 1-cycle latency where special:
  - `0x7F800000 × 0x00000000` → `0x7FC00000`.
  - `0xFF800000 × 0x40000000` → `0xFF800000`.
  - `0x7F7FFFFF × 0x40000000` → `0x7F800000` (overflow).
  - `0x00800000 × 0x00800000` → `0x00000000` (underflow).
  - `0x00000001 × 0x3F800000` → `0x00000000`.
- **Backpressure**:
  - Hold `out_ready`=0 for 10 cycles after `out_valid` rises → `op` stable, `in_ready`=0, and a new `in_valid` pulse is ignored.
  - Raise `out_ready` → IDLE next cycle, `in_ready`=1.
- **Reset mid-operation**:
  - Pulse `rst_n` low during MUL cycle 5 → `out_valid`=0, `op`=0, `in_ready`=1 immediately.
  - The next accepted pair produces the correct product with full latency.
- **Vector regression**: stream all of `mult.tv` with random `in_valid` and `out_ready` gaps → zero mismatches against `opexp`.
